data_mem_responder: RTL and testbench

Memory-side responder for the 16-bit pipelined CPU's data-memory port. It accepts single-word read/write requests (ReadM/WriteM) from the MEM stage and serves them from an internal word array after a fixed, parameterised latency. It signals completion with a one-cycle MemReady pulse and drives a combinational stall request that the pipeline uses to freeze IF/ID/EX/MEM while an access is outstanding.

---
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the 16-bit pipelined CPU's data-memory port.
// Serves single-word read/write requests from the MEM stage out of an internal
// word array after a fixed latency, pulses MemReady for one cycle on
// completion and requests a pipeline stall while an access is outstanding.
//
// Parameters:
//   WORD_SIZE  - data and address width
//   ADDR_WIDTH - array index width (depth = 2**ADDR_WIDTH words)
//   LATENCY    - cycles from request acceptance to MemReady (1..15)
//
// Ports:
//   Clk        - system clock, rising edge
//   Reset_N    - asynchronous active-low reset
//   ReadM      - read request, held until MemReady
//   WriteM     - write request, held until MemReady
//   Address    - word address; only [ADDR_WIDTH-1:0] indexes the array
//   WriteData  - write data, sampled at acceptance
//   InitWrite  - preload strobe (honoured only in IDLE with no acceptance)
//   InitAddr   - preload index
//   InitData   - preload data
//   ReadData   - registered read result, held until the next read completes
//   MemReady   - one-cycle completion pulse
//   MemStall   - combinational stall request to the pipeline
//   Error      - sticky flag: ReadM and WriteM seen together in IDLE
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  ReadM,
    input  logic                  WriteM,
    input  logic [WORD_SIZE-1:0]  Address,
    input  logic [WORD_SIZE-1:0]  WriteData,
    input  logic                  InitWrite,
    input  logic [ADDR_WIDTH-1:0] InitAddr,
    input  logic [WORD_SIZE-1:0]  InitData,
    output logic [WORD_SIZE-1:0]  ReadData,
    output logic                  MemReady,
    output logic                  MemStall,
    output logic                  Error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter starts at LATENCY-1 so that the WAIT->RESP edge lands exactly
    // LATENCY edges after acceptance.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_q,    state_d;
    logic [3:0]            cnt_q,      cnt_d;
    logic                  is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [WORD_SIZE-1:0]  wdata_q,    wdata_d;
    logic [WORD_SIZE-1:0]  rdata_q,    rdata_d;
    logic                  error_q,    error_d;

    logic [WORD_SIZE-1:0]  mem [DEPTH];

    logic                  accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_SIZE-1:0]  mem_wdata;

    // Upper address bits alias onto the same word and are deliberately unused.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[WORD_SIZE-1:ADDR_WIDTH];

    // A request is taken only in IDLE and only when exactly one direction
    // is asserted; both together is a protocol error.
    assign accept = (state_q == S_IDLE) && (ReadM ^ WriteM);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (ReadM && WriteM) begin
                    error_d = 1'b1;
                end else if (accept) begin
                    is_write_d = WriteM;
                    addr_d     = Address[ADDR_WIDTH-1:0];
                    wdata_d    = WriteData;
                    cnt_d      = CNT_LOAD;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (!is_write_q) begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Always return to IDLE so a held request is never re-accepted
                // on the edge that ends the MemReady cycle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single array write port: either the committed write (WAIT->RESP edge)
    // or a preload in an IDLE cycle with no acceptance. The two are exclusive
    // by state. Gating with Reset_N keeps reset from ever writing the array.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        if ((state_q == S_WAIT) && (cnt_q == 4'd0) && is_write_q) begin
            mem_we = 1'b1;
        end else if ((state_q == S_IDLE) && !accept && InitWrite) begin
            mem_we    = 1'b1;
            mem_waddr = InitAddr;
            mem_wdata = InitData;
        end
        mem_we = mem_we && Reset_N;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_N) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!Reset_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    // NOTE: the array has no reset branch; its contents survive Reset_N and
    // it maps onto plain RAM rather than a bank of resettable flops.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ReadData = rdata_q;
    assign MemReady = (state_q == S_RESP);
    assign Error    = error_q;
    assign MemStall = (ReadM | WriteM) & ~MemReady;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Scoreboard bench for data_mem_responder. The driver issues requests and
// pushes the expected completion (cycle and read data) computed from a plain
// word-array model; a monitor on the falling edge pops and compares whenever
// MemReady is seen, and checks MemStall every cycle.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int WS  = 16;
    localparam int AW  = 8;
    localparam int LAT = 4;

    logic          Clk = 1'b0;
    logic          Reset_N;
    logic          ReadM;
    logic          WriteM;
    logic [WS-1:0] Address;
    logic [WS-1:0] WriteData;
    logic          InitWrite;
    logic [AW-1:0] InitAddr;
    logic [WS-1:0] InitData;
    logic [WS-1:0] ReadData;
    logic          MemReady;
    logic          MemStall;
    logic          Error;

    data_mem_responder #(
        .WORD_SIZE  (WS),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .ReadM     (ReadM),
        .WriteM    (WriteM),
        .Address   (Address),
        .WriteData (WriteData),
        .InitWrite (InitWrite),
        .InitAddr  (InitAddr),
        .InitData  (InitData),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .MemStall  (MemStall),
        .Error     (Error)
    );

    always #5 Clk = ~Clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge Clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          ready_cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [256];
    logic [15:0] last_read;
    // First edge at which the responder can accept a new request.
    int          free_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: samples on the falling edge, inputs change at negedge+1.
    // -------------------------------------------------------------------------
    exp_t mon_e;
    bit   mon_exp_ready;
    always @(negedge Clk) begin
        if (Reset_N === 1'b1) begin
            mon_exp_ready = (sbq.size() > 0) && (sbq[0].ready_cyc == cyc);
            check("mem_stall", MemStall, (ReadM | WriteM) & ~mon_exp_ready);
            if (MemReady) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ready", MemReady, 1'b0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ready_cycle", cyc, mon_e.ready_cyc);
                    if (mon_e.is_read) begin
                        check("read_data", ReadData, mon_e.data);
                        last_read = mon_e.data;
                    end else begin
                        check("read_data_held", ReadData, last_read);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) tick();
    endtask

    task automatic preload(input logic [7:0] idx, input logic [15:0] data);
        wait_idle();
        InitWrite = 1'b1;
        InitAddr  = idx;
        InitData  = data;
        tick();
        InitWrite = 1'b0;
        model[idx] = data;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (MemReady) break;
            tick();
        end
        if (!MemReady) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: MemReady not seen, expected at cycle %0d", free_edge - 2);
        end
        // Requester drops its request at the edge ending the MemReady cycle.
        ReadM  = 1'b0;
        WriteM = 1'b0;
    endtask

    // Issue one access; may be called straight from the MemReady cycle of the
    // previous one (back-to-back).
    task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                             input bit drop, input bit poke_init);
        int   acc;
        exp_t e;
        ReadM     = !wr;
        WriteM    = wr;
        Address   = addr;
        WriteData = data;
        acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        e.is_read   = !wr;
        e.ready_cyc = acc + LAT;
        e.data      = wr ? data : model[addr[7:0]];
        if (wr) model[addr[7:0]] = data;
        sbq.push_back(e);
        // Edge acc+LAT is RESP entry, +1 returns to IDLE, +2 can accept.
        free_edge = acc + LAT + 2;
        while (cyc < acc) tick();
        // Accepted: later input changes must have no effect.
        Address   = 16'($urandom);
        WriteData = 16'($urandom);
        if (drop) begin
            ReadM  = 1'b0;
            WriteM = 1'b0;
        end
        if (poke_init) begin
            InitWrite = 1'b1;
            InitAddr  = addr[7:0];
            InitData  = ~data;
            tick();
            InitWrite = 1'b0;
        end
        wait_ready();
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        Reset_N   = 1'b0;
        ReadM     = 1'b0;
        WriteM    = 1'b0;
        Address   = '0;
        WriteData = '0;
        InitWrite = 1'b0;
        InitAddr  = '0;
        InitData  = '0;
        last_read = '0;
        repeat (3) tick();
        Reset_N = 1'b1;
        tick();

        // Fill the whole array so every read has a defined expectation.
        for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
        preload(8'h10, 16'hBEEF);

        // Reset with a read pending; a preload strobe under reset is ignored.
        Reset_N   = 1'b0;
        ReadM     = 1'b1;
        Address   = 16'h0010;
        InitWrite = 1'b1;
        InitAddr  = 8'h10;
        InitData  = 16'h0000;
        tick();
        tick();
        InitWrite = 1'b0;
        check("rst_read_data", ReadData, 16'h0000);
        check("rst_mem_ready", MemReady, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_mem_stall", MemStall, 1'b1);
        Reset_N   = 1'b1;
        free_edge = 0;
        last_read = '0;
        // Accepted at the first edge after release; array survived reset.
        do_access(1'b0, 16'h0010, 16'h0, 1'b0, 1'b0);

        // Write then back-to-back reads, including an aliased address.
        do_access(1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0);
        do_access(1'b0, 16'h0020, 16'h0, 1'b0, 1'b0);
        do_access(1'b0, 16'h0120, 16'h0, 1'b0, 1'b0);
        do_access(1'b0, 16'h0105, 16'h0, 1'b0, 1'b0);
        do_access(1'b0, 16'h0005, 16'h0, 1'b0, 1'b0);

        // Protocol error: both requests for one cycle.
        wait_idle();
        ReadM     = 1'b1;
        WriteM    = 1'b1;
        Address   = 16'h0040;
        WriteData = 16'hDEAD;
        tick();
        ReadM  = 1'b0;
        WriteM = 1'b0;
        check("error_set", Error, 1'b1);
        repeat (3) tick();
        check("error_sticky", Error, 1'b1);
        do_access(1'b0, 16'h0040, 16'h0, 1'b0, 1'b0);

        // Preload strobe during WAIT is ignored.
        do_access(1'b0, 16'h0050, 16'h0, 1'b0, 1'b1);
        do_access(1'b0, 16'h0050, 16'h0, 1'b0, 1'b0);

        // Reset in the middle of a write abandons it.
        preload(8'h30, 16'h5555);
        wait_idle();
        WriteM    = 1'b1;
        Address   = 16'h0030;
        WriteData = 16'hAAAA;
        begin
            int e0;
            e0 = cyc + 1;
            while (cyc < e0 + 2) tick();
        end
        Reset_N = 1'b0;
        WriteM  = 1'b0;
        repeat (2) tick();
        check("midrst_mem_ready", MemReady, 1'b0);
        check("midrst_read_data", ReadData, 16'h0000);
        check("midrst_error", Error, 1'b0);
        Reset_N   = 1'b1;
        free_edge = 0;
        last_read = '0;
        tick();
        do_access(1'b0, 16'h0030, 16'h0, 1'b0, 1'b0);

        // Dropped requests still complete exactly once.
        wait_idle();
        do_access(1'b0, 16'h0010, 16'h0, 1'b1, 1'b0);
        repeat (LAT + 3) tick();
        do_access(1'b1, 16'h0060, 16'hC0DE, 1'b1, 1'b0);
        repeat (LAT + 3) tick();
        do_access(1'b0, 16'h0060, 16'h0, 1'b0, 1'b0);

        // Randomized traffic over a small index set with random alias bits.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
            do_access(1'($urandom_range(0, 1)), a, 16'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end

        repeat (LAT + 4) tick();
        check("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
